// File: rtl/addatone_pkg.sv
// Shared definitions for the additive oscillator control path: sequencer
// state encoding, default widths and the sample-interval clamp.
package addatone_pkg;

    localparam int          ACC_W_DEFAULT           = 32;
    localparam logic [15:0] DEFAULT_SAMPLE_INTERVAL = 16'd1000;
    localparam logic [15:0] MIN_SAMPLE_INTERVAL     = 16'd2;

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_SCALE      = 3'd1,
        ST_SCALE_WAIT = 3'd2,
        ST_ADD_WAIT   = 3'd3,
        ST_NEXT       = 3'd4,
        ST_LATCH      = 3'd5,
        ST_WAIT_TICK  = 3'd6,
        ST_SEND       = 3'd7
    } seq_state_t;

    // An interval below two clocks would leave no room between ticks.
    function automatic logic [15:0] clamp_interval(input logic [15:0] interval);
        return (interval < MIN_SAMPLE_INTERVAL) ? MIN_SAMPLE_INTERVAL : interval;
    endfunction

endpackage

// File: rtl/sample_tick_timer.sv
// Free-running sample period timer; emits a one-cycle tick every
// i_Sample_Interval clocks, picking up a new interval only at wrap.
module sample_tick_timer
    import addatone_pkg::*;
(
    input  logic        Main_Clock,
    input  logic        Reset,
    input  logic [15:0] i_Sample_Interval,
    output logic        o_Tick
);

    logic [15:0] timer_r;
    logic [15:0] interval_r;
    logic        tick_r;

    // Period counter; the interval register is refreshed only on wrap so a
    // mid-period change never shortens or stretches the running period.
    always_ff @(posedge Main_Clock) begin
        if (Reset) begin
            timer_r    <= 16'd0;
            interval_r <= clamp_interval(i_Sample_Interval);
            tick_r     <= 1'b0;
        end else if (timer_r >= interval_r - 16'd1) begin
            timer_r    <= 16'd0;
            interval_r <= clamp_interval(i_Sample_Interval);
            tick_r     <= 1'b1;
        end else begin
            timer_r    <= timer_r + 16'd1;
            tick_r     <= 1'b0;
        end
    end

    assign o_Tick = tick_r;

endmodule

// File: rtl/harmonic_sequencer.sv
// Per-sample harmonic walk: deals harmonics round-robin to the scaler/adder
// channels, latches the channel totals and fires the DAC send on the sample tick.
module harmonic_sequencer
    import addatone_pkg::*;
#(
    parameter int NUM_CHANNELS  = 2,
    parameter int HARM_W        = 8,
    parameter int MAX_HARMONICS = 200,
    parameter int ACC_W         = ACC_W_DEFAULT
) (
    input  logic                          Main_Clock,
    input  logic                          Reset,
    input  logic [HARM_W-1:0]             i_Harmonic_Count,
    input  logic [15:0]                   i_Sample_Interval,
    input  logic                          i_Sample_Ready,
    input  logic                          i_Freq_Too_High,
    input  logic [NUM_CHANNELS-1:0]       i_Scaler_Ready,
    input  logic [NUM_CHANNELS*ACC_W-1:0] i_Adder_Total,
    input  logic                          i_Clear_Overrun,
    output logic [HARM_W-1:0]             o_Harmonic,
    output logic                          o_Next_Sample,
    output logic [NUM_CHANNELS-1:0]       o_Scaler_Start,
    output logic                          o_Scaler_Restart,
    output logic [NUM_CHANNELS-1:0]       o_Adder_Start,
    output logic                          o_Adder_Clear,
    output logic [NUM_CHANNELS*ACC_W-1:0] o_Totals,
    output logic                          o_DAC_Send,
    output logic                          o_Overrun,
    output logic [HARM_W-1:0]             o_Last_Count
);

    localparam int                      CH_W     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [CH_W-1:0]         CH_LAST  = CH_W'(NUM_CHANNELS - 1);
    localparam logic [HARM_W-1:0]       HARM_MAX = HARM_W'(MAX_HARMONICS);
    localparam logic [HARM_W-1:0]       HARM_TOP = {HARM_W{1'b1}};
    localparam logic [NUM_CHANNELS-1:0] CH_ONE   = NUM_CHANNELS'(1'b1);

    seq_state_t                    state_r;
    logic [HARM_W-1:0]             harm_r;
    logic [CH_W-1:0]               ch_r;
    logic                          pending_r;
    logic                          overrun_r;
    logic                          next_sample_r;
    logic [NUM_CHANNELS-1:0]       scaler_start_r;
    logic                          scaler_restart_r;
    logic [NUM_CHANNELS-1:0]       adder_start_r;
    logic                          adder_clear_r;
    logic [NUM_CHANNELS*ACC_W-1:0] totals_r;
    logic                          dac_send_r;
    logic [HARM_W-1:0]             last_count_r;

    logic                          tick_s;
    logic [HARM_W-1:0]             count_clamped_s;
    logic [CH_W-1:0]               ch_next_s;
    logic                          walk_done_s;
    logic                          tick_allowed_s;
    logic                          overrun_set_s;

    sample_tick_timer u_timer (
        .Main_Clock        (Main_Clock),
        .Reset             (Reset),
        .i_Sample_Interval (i_Sample_Interval),
        .o_Tick            (tick_s)
    );

    // Walk termination, channel wrap and overrun qualification.
    always_comb begin
        count_clamped_s = (i_Harmonic_Count > HARM_MAX) ? HARM_MAX : i_Harmonic_Count;
        ch_next_s       = (ch_r == CH_LAST) ? {CH_W{1'b0}} : ch_r + CH_W'(1'b1);
        walk_done_s     = (harm_r >= count_clamped_s) || i_Freq_Too_High || (harm_r == HARM_TOP);
        tick_allowed_s  = (state_r == ST_WAIT_TICK) || (state_r == ST_SEND) || (state_r == ST_INIT);
        overrun_set_s   = tick_s && (pending_r || !tick_allowed_s);
    end

    // Sequencer FSM; each output register is loaded on the transition into
    // the state it belongs to, so strobes line up with the state they mark.
    always_ff @(posedge Main_Clock) begin
        if (Reset) begin
            state_r          <= ST_INIT;
            harm_r           <= {HARM_W{1'b0}};
            ch_r             <= {CH_W{1'b0}};
            next_sample_r    <= 1'b0;
            scaler_start_r   <= {NUM_CHANNELS{1'b0}};
            scaler_restart_r <= 1'b0;
            adder_start_r    <= {NUM_CHANNELS{1'b0}};
            adder_clear_r    <= 1'b0;
            totals_r         <= {(NUM_CHANNELS*ACC_W){1'b0}};
            dac_send_r       <= 1'b0;
            last_count_r     <= {HARM_W{1'b0}};
        end else begin
            scaler_start_r   <= {NUM_CHANNELS{1'b0}};
            scaler_restart_r <= 1'b0;
            adder_start_r    <= {NUM_CHANNELS{1'b0}};
            dac_send_r       <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    adder_clear_r <= 1'b0;
                    state_r       <= ST_ADD_WAIT;
                end
                ST_SCALE: begin
                    state_r <= ST_SCALE_WAIT;
                end
                ST_SCALE_WAIT: begin
                    if (i_Scaler_Ready[ch_r]) begin
                        state_r <= ST_ADD_WAIT;
                    end else begin
                        state_r <= ST_SCALE_WAIT;
                    end
                end
                ST_ADD_WAIT: begin
                    if (i_Sample_Ready) begin
                        adder_start_r <= CH_ONE << ch_r;
                        next_sample_r <= 1'b1;
                        state_r       <= ST_NEXT;
                    end else begin
                        state_r <= ST_ADD_WAIT;
                    end
                end
                ST_NEXT: begin
                    // The index is left on the last accumulated harmonic so
                    // the latched count is simply that index plus one.
                    if (walk_done_s) begin
                        totals_r      <= i_Adder_Total;
                        last_count_r  <= harm_r + HARM_W'(1'b1);
                        adder_clear_r <= 1'b1;
                        next_sample_r <= 1'b0;
                        state_r       <= ST_LATCH;
                    end else begin
                        harm_r         <= harm_r + HARM_W'(1'b1);
                        ch_r           <= ch_next_s;
                        scaler_start_r <= CH_ONE << ch_next_s;
                        next_sample_r  <= 1'b0;
                        state_r        <= ST_SCALE;
                    end
                end
                ST_LATCH: begin
                    state_r <= ST_WAIT_TICK;
                end
                ST_WAIT_TICK: begin
                    if (pending_r || tick_s) begin
                        dac_send_r       <= 1'b1;
                        scaler_restart_r <= 1'b1;
                        harm_r           <= {HARM_W{1'b0}};
                        ch_r             <= {CH_W{1'b0}};
                        next_sample_r    <= 1'b1;
                        state_r          <= ST_SEND;
                    end else begin
                        state_r <= ST_WAIT_TICK;
                    end
                end
                ST_SEND: begin
                    adder_clear_r <= 1'b0;
                    state_r       <= ST_INIT;
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

    // Tick bookkeeping: a tick always wins over the SEND clear, and a new
    // overrun event wins over the software clear.
    always_ff @(posedge Main_Clock) begin
        if (Reset) begin
            pending_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (tick_s) begin
                pending_r <= 1'b1;
            end else if (state_r == ST_SEND) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
            if (overrun_set_s) begin
                overrun_r <= 1'b1;
            end else if (i_Clear_Overrun) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    assign o_Harmonic       = harm_r;
    assign o_Next_Sample    = next_sample_r;
    assign o_Scaler_Start   = scaler_start_r;
    assign o_Scaler_Restart = scaler_restart_r;
    assign o_Adder_Start    = adder_start_r;
    assign o_Adder_Clear    = adder_clear_r;
    assign o_Totals         = totals_r;
    assign o_DAC_Send       = dac_send_r;
    assign o_Overrun        = overrun_r;
    assign o_Last_Count     = last_count_r;

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Scoreboard bench: a two-channel and a three-channel sequencer driven by
// directed scenarios, with monitors checking every adder strobe and DAC send.
module tb_harmonic_sequencer;
    import addatone_pkg::*;

    logic clk;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Two-channel instance
    logic        a_rst, a_sready, a_freq, a_clr;
    logic [7:0]  a_count;
    logic [15:0] a_interval;
    logic [1:0]  a_scready;
    logic [63:0] a_total;
    logic [7:0]  a_harm, a_last;
    logic        a_next, a_restart, a_clear, a_send, a_overrun;
    logic [1:0]  a_scstart, a_adstart;
    logic [63:0] a_totals;

    // Three-channel instance
    logic        b_rst, b_sready, b_freq, b_clr;
    logic [7:0]  b_count;
    logic [15:0] b_interval;
    logic [2:0]  b_scready;
    logic [95:0] b_total;
    logic [7:0]  b_harm, b_last;
    logic        b_next, b_restart, b_clear, b_send, b_overrun;
    logic [2:0]  b_scstart, b_adstart;
    logic [95:0] b_totals;

    logic        ftoh_en;

    logic [9:0]   a_addq[$];
    logic [71:0]  a_sendq[$];
    logic [10:0]  b_addq[$];
    logic [103:0] b_sendq[$];

    wire logic [88:0]  a_outs = {a_harm, a_next, a_scstart, a_restart, a_adstart, a_clear,
                                 a_totals, a_send, a_overrun, a_last};
    wire logic [122:0] b_outs = {b_harm, b_next, b_scstart, b_restart, b_adstart, b_clear,
                                 b_totals, b_send, b_overrun, b_last};

    harmonic_sequencer #(.NUM_CHANNELS(2), .HARM_W(8), .MAX_HARMONICS(200), .ACC_W(32)) dut_a (
        .Main_Clock(clk), .Reset(a_rst), .i_Harmonic_Count(a_count),
        .i_Sample_Interval(a_interval), .i_Sample_Ready(a_sready), .i_Freq_Too_High(a_freq),
        .i_Scaler_Ready(a_scready), .i_Adder_Total(a_total), .i_Clear_Overrun(a_clr),
        .o_Harmonic(a_harm), .o_Next_Sample(a_next), .o_Scaler_Start(a_scstart),
        .o_Scaler_Restart(a_restart), .o_Adder_Start(a_adstart), .o_Adder_Clear(a_clear),
        .o_Totals(a_totals), .o_DAC_Send(a_send), .o_Overrun(a_overrun), .o_Last_Count(a_last)
    );

    harmonic_sequencer #(.NUM_CHANNELS(3), .HARM_W(8), .MAX_HARMONICS(200), .ACC_W(32)) dut_b (
        .Main_Clock(clk), .Reset(b_rst), .i_Harmonic_Count(b_count),
        .i_Sample_Interval(b_interval), .i_Sample_Ready(b_sready), .i_Freq_Too_High(b_freq),
        .i_Scaler_Ready(b_scready), .i_Adder_Total(b_total), .i_Clear_Overrun(b_clr),
        .o_Harmonic(b_harm), .o_Next_Sample(b_next), .o_Scaler_Start(b_scstart),
        .o_Scaler_Restart(b_restart), .o_Adder_Start(b_adstart), .o_Adder_Clear(b_clear),
        .o_Totals(b_totals), .o_DAC_Send(b_send), .o_Overrun(b_overrun), .o_Last_Count(b_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever @(posedge clk) cyc++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected strobes for one walk over harmonics 0..last_h, then its send.
    task automatic push_walk_a(input int last_h, input logic [63:0] tot);
        for (int h = 0; h <= last_h; h++) a_addq.push_back({8'(h), 2'b01 << (h % 2)});
        a_sendq.push_back({8'(last_h + 1), tot});
    endtask

    task automatic push_walk_b(input int last_h, input logic [95:0] tot);
        for (int h = 0; h <= last_h; h++) b_addq.push_back({8'(h), 3'b001 << (h % 3)});
        b_sendq.push_back({8'(last_h + 1), tot});
    endtask

    task automatic wait_sig(input int which, input int budget, input string name);
        logic hit;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            case (which)
                0:       hit = a_send;
                1:       hit = b_send;
                2:       hit = a_clear;
                3:       hit = (a_scstart != 2'b00);
                4:       hit = (a_adstart != 2'b00);
                default: hit = 1'b0;
            endcase
            if (hit) return;
        end
        total++;
        bad++;
        $display("FAIL %s: got timeout after %0d cycles expected event", name, budget);
    endtask

    // Two-channel monitor
    initial begin
        logic [9:0]  ea;
        logic [71:0] es;
        forever begin
            @(negedge clk);
            if (a_adstart != 2'b00) begin
                if (a_addq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL a_add_unexpected: got %0h expected none", {a_harm, a_adstart});
                end else begin
                    ea = a_addq.pop_front();
                    check("a_add", {a_harm, a_adstart}, ea);
                end
            end
            if (a_send) begin
                if (a_sendq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL a_send_unexpected: got %0h expected none", a_last);
                end else begin
                    es = a_sendq.pop_front();
                    check("a_send_count_totals", {a_last, a_totals}, es);
                end
            end
        end
    end

    // Three-channel monitor
    initial begin
        logic [10:0]  ea;
        logic [103:0] es;
        forever begin
            @(negedge clk);
            if (b_adstart != 3'b000) begin
                if (b_addq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_add_unexpected: got %0h expected none", {b_harm, b_adstart});
                end else begin
                    ea = b_addq.pop_front();
                    check("b_add", {b_harm, b_adstart}, ea);
                end
            end
            if (b_send) begin
                if (b_sendq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL b_send_unexpected: got %0h expected none", b_last);
                end else begin
                    es = b_sendq.pop_front();
                    check("b_send_count_totals", {b_last, b_totals}, es);
                end
            end
        end
    end

    // Nyquist emulation: flag the harmonic once index 3 is reached, drop at latch.
    initial begin
        a_freq = 1'b0;
        forever begin
            @(negedge clk);
            if (!ftoh_en) a_freq = 1'b0;
            else if (a_clear) a_freq = 1'b0;
            else if (a_harm == 8'd3) a_freq = 1'b1;
        end
    end

    initial begin
        int t_prev;
        int t_latch;
        a_rst = 1'b1; a_count = 8'd5; a_interval = 16'd100; a_sready = 1'b1;
        a_scready = 2'b11; a_total = 64'hDEAD_BEEF_0000_0011; a_clr = 1'b0;
        b_rst = 1'b1; b_count = 8'd7; b_interval = 16'd100; b_sready = 1'b1;
        b_scready = 3'b111; b_total = 96'h0000_0003_FFFF_FFFE_1234_5678;
        b_clr = 1'b0; b_freq = 1'b0; ftoh_en = 1'b0;
        repeat (3) @(negedge clk);
        check("a_reset_outs", a_outs, 128'd0);
        check("b_reset_outs", b_outs, 128'd0);

        // 1: two channels, count 5, interval 100
        push_walk_a(5, 64'hDEAD_BEEF_0000_0011);
        a_rst = 1'b0;
        wait_sig(0, 300, "t1_send0");
        t_prev = cyc;
        push_walk_a(5, 64'hDEAD_BEEF_0000_0011);
        wait_sig(0, 300, "t1_send1");
        check("t1_period1", 128'(cyc - t_prev), 128'd100);
        t_prev = cyc;
        push_walk_a(5, 64'hDEAD_BEEF_0000_0011);
        wait_sig(0, 300, "t1_send2");
        check("t1_period2", 128'(cyc - t_prev), 128'd100);
        check("t1_no_overrun", a_overrun, 1'b0);
        a_rst = 1'b1;

        // 2: three channels, count 7, totals change between walks
        repeat (2) @(negedge clk);
        push_walk_b(7, 96'h0000_0003_FFFF_FFFE_1234_5678);
        b_rst = 1'b0;
        wait_sig(1, 300, "t2_send0");
        b_total = 96'h8000_0000_0000_0001_0000_00AB;
        push_walk_b(7, 96'h8000_0000_0000_0001_0000_00AB);
        @(negedge clk);
        check("t2_totals_hold", b_totals, 96'h0000_0003_FFFF_FFFE_1234_5678);
        wait_sig(1, 300, "t2_send1");
        b_rst = 1'b1;

        // 3: Nyquist limit at harmonic 3 with count 50
        a_count = 8'd50; a_total = 64'h0000_0004_0000_0003; ftoh_en = 1'b1;
        repeat (2) @(negedge clk);
        push_walk_a(3, 64'h0000_0004_0000_0003);
        a_rst = 1'b0;
        wait_sig(0, 300, "t3_send0");
        push_walk_a(3, 64'h0000_0004_0000_0003);
        wait_sig(0, 300, "t3_send1");
        a_rst = 1'b1;
        ftoh_en = 1'b0;

        // 4: sample lookup stalled for 150 clocks forces a late send
        a_count = 8'd5; a_sready = 1'b0; a_total = 64'h0101_0101_7FFF_FFFF;
        repeat (2) @(negedge clk);
        push_walk_a(5, 64'h0101_0101_7FFF_FFFF);
        a_rst = 1'b0;
        repeat (150) @(negedge clk);
        check("t4_overrun_set", a_overrun, 1'b1);
        a_sready = 1'b1;
        wait_sig(2, 100, "t4_latch");
        t_latch = cyc;
        wait_sig(0, 100, "t4_send");
        check("t4_send_delay", 128'(cyc - t_latch), 128'd2);
        check("t4_overrun_held", a_overrun, 1'b1);
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        check("t4_overrun_clr", a_overrun, 1'b0);
        a_rst = 1'b1;

        // 5: count 255 clamps to 200
        a_count = 8'd255; a_interval = DEFAULT_SAMPLE_INTERVAL; a_total = 64'hFFFF_FF38_0000_00C8;
        repeat (2) @(negedge clk);
        push_walk_a(200, 64'hFFFF_FF38_0000_00C8);
        a_rst = 1'b0;
        wait_sig(2, 2000, "t5_latch");
        check("t5_last_harm", a_harm, 8'd200);
        wait_sig(0, 1000, "t5_send");
        a_rst = 1'b1;

        // 6: reset while stalled in SCALE_WAIT
        a_count = 8'd5; a_interval = 16'd100; a_scready = 2'b00;
        repeat (2) @(negedge clk);
        a_addq.push_back({8'd0, 2'b01});
        a_rst = 1'b0;
        wait_sig(3, 50, "t6_scale");
        @(negedge clk);
        check("t6_stall_harm", a_harm, 8'd1);
        a_rst = 1'b1;
        @(negedge clk);
        check("t6_reset_outs", a_outs, 128'd0);
        a_addq.push_back({8'd0, 2'b01});
        a_rst = 1'b0;
        wait_sig(4, 50, "t6_first_add");
        a_rst = 1'b1;
        @(negedge clk);

        check("a_queues_drained", 128'(a_addq.size() + a_sendq.size()), 128'd0);
        check("b_queues_drained", 128'(b_addq.size() + b_sendq.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
